// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// States, register-address width and the reset value of the control group.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    MC_BUSY  = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic memwb_hold;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{
    pc_write:    1'b0,
    ifid_hold:   1'b0,
    idex_hold:   1'b0,
    exmem_hold:  1'b0,
    memwb_hold:  1'b0,
    ifid_flush:  1'b1,
    idex_flush:  1'b1,
    exmem_flush: 1'b1,
    memwb_flush: 1'b1
  };

  localparam ctl_t CTL_RUN = '{
    pc_write:    1'b1,
    ifid_hold:   1'b0,
    idex_hold:   1'b0,
    exmem_hold:  1'b0,
    memwb_hold:  1'b0,
    ifid_flush:  1'b0,
    idex_flush:  1'b0,
    exmem_flush: 1'b0,
    memwb_flush: 1'b0
  };

endpackage

// File: rtl/hazard_ctrl_mc_stall_counter.sv
// Remaining-stall countdown for multi-cycle EX operations.
// Loads len-1, decrements on request while nonzero, flags nonzero now/next.
module mc_stall_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  output logic             busy_d_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign busy_o = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i - ONE;
    end else if (dec_i && busy_o) begin
      cnt_d = cnt_q - ONE;
    end
  end

  assign busy_d_o = (cnt_d != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hold/flush/PC-write sequencing for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall and branch-flush counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  id_branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  ex_mc_start_i,
  input  logic [CNT_W-1:0]      ex_mc_len_i,
  output logic                  pc_write_o,
  output logic                  ifid_hold_o,
  output logic                  idex_hold_o,
  output logic                  exmem_hold_o,
  output logic                  memwb_hold_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  exmem_flush_o,
  output logic                  memwb_flush_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_events_o
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e state_q;
  state_e state_d;
  ctl_t   ctl;
  logic   active;
  logic   mem_wait;
  logic   rs1_hit;
  logic   rs2_hit;
  logic   load_use;
  logic   mc_busy;
  logic   mc_busy_d;
  logic   mc_load;
  logic   mc_dec;

  assign active   = (state_q != IDLE);
  assign mem_wait = mem_req_i & ~mem_ready_i;
  assign rs1_hit  = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit  = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use = ex_memread_i & (ex_rd_i != '0)
                  & (rs1_hit | rs2_hit);

  // Lengths 0 and 1 complete in the entry cycle, so no countdown.
  assign mc_load = (state_q == RUN) & ex_mc_start_i
                 & (ex_mc_len_i > ONE);
  assign mc_dec  = active & ~mem_wait;

  mc_stall_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (mc_load),
    .dec_i   (mc_dec),
    .len_i   (ex_mc_len_i),
    .busy_o  (mc_busy),
    .busy_d_o(mc_busy_d)
  );

  always_comb begin
    ctl = CTL_RESET;
    if (active) begin
      ctl = CTL_RUN;
      if (mem_wait) begin
        ctl.pc_write   = 1'b0;
        ctl.ifid_hold  = 1'b1;
        ctl.idex_hold  = 1'b1;
        ctl.exmem_hold = 1'b1;
        ctl.memwb_hold = 1'b1;
      end else if (mc_busy) begin
        ctl.pc_write    = 1'b0;
        ctl.ifid_hold   = 1'b1;
        ctl.idex_hold   = 1'b1;
        ctl.exmem_hold  = 1'b1;
        ctl.memwb_flush = 1'b1;
      end else if (load_use) begin
        ctl.pc_write   = 1'b0;
        ctl.ifid_hold  = 1'b1;
        ctl.idex_flush = 1'b1;
      end else if (id_branch_taken_i) begin
        ctl.ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = start_i ? RUN : IDLE;
      RUN, MEM_WAIT, MC_BUSY: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (mc_busy_d) begin
          state_d = MC_BUSY;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_write_o    = ctl.pc_write;
  assign ifid_hold_o   = ctl.ifid_hold;
  assign idex_hold_o   = ctl.idex_hold;
  assign exmem_hold_o  = ctl.exmem_hold;
  assign memwb_hold_o  = ctl.memwb_hold;
  assign ifid_flush_o  = ctl.ifid_flush;
  assign idex_flush_o  = ctl.idex_flush;
  assign exmem_flush_o = ctl.exmem_flush;
  assign memwb_flush_o = ctl.memwb_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        br_flush;

  // Outside IDLE the IF/ID flush only ever comes from a taken branch.
  assign br_flush = active & ctl.ifid_flush;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (active && !ctl.pc_write) begin
        stall_q <= stall_q + 32'd1;
      end
      if (br_flush) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: rule-level model pushes expectations,
// a negedge monitor pops and compares the DUT control vector.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       memrd;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic       mcs;
    logic [3:0] len;
  } stim_t;

  typedef struct {
    int         cyc;
    logic [8:0] v;
    int         st;
    int         fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] id_rs1_i = '0;
  logic [4:0] id_rs2_i = '0;
  logic       id_use_rs1_i = 1'b0;
  logic       id_use_rs2_i = 1'b0;
  logic       ex_memread_i = 1'b0;
  logic [4:0] ex_rd_i = '0;
  logic       id_branch_taken_i = 1'b0;
  logic       mem_req_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       ex_mc_start_i = 1'b0;
  logic [3:0] ex_mc_len_i = '0;
  logic       pc_write_o;
  logic       ifid_hold_o, idex_hold_o, exmem_hold_o, memwb_hold_o;
  logic       ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_events_o;
`endif

  hazard_ctrl #(.CNT_W(4)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n_i),
    .start_i          (start_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_use_rs1_i     (id_use_rs1_i),
    .id_use_rs2_i     (id_use_rs2_i),
    .ex_memread_i     (ex_memread_i),
    .ex_rd_i          (ex_rd_i),
    .id_branch_taken_i(id_branch_taken_i),
    .mem_req_i        (mem_req_i),
    .mem_ready_i      (mem_ready_i),
    .ex_mc_start_i    (ex_mc_start_i),
    .ex_mc_len_i      (ex_mc_len_i),
    .pc_write_o       (pc_write_o),
    .ifid_hold_o      (ifid_hold_o),
    .idex_hold_o      (idex_hold_o),
    .exmem_hold_o     (exmem_hold_o),
    .memwb_hold_o     (memwb_hold_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_flush_o     (idex_flush_o),
    .exmem_flush_o    (exmem_flush_o),
    .memwb_flush_o    (memwb_flush_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o   (stall_cycles_o),
    .flush_events_o   (flush_events_o)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: pipeline running flag, remaining multi-cycle stall
  // cycles, whether last cycle was a memory wait, and event tallies.
  bit m_run = 0;
  int m_rem = 0;
  bit m_lastw = 0;
  int m_st = 0;
  int m_fl = 0;

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.start = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit mw, lu, pc, brf;
    bit [3:0] h, f;
    @(posedge clk);
    #1;
    rst_n_i = ~s.rst;
    start_i = s.start;
    id_rs1_i = s.rs1;
    id_rs2_i = s.rs2;
    id_use_rs1_i = s.u1;
    id_use_rs2_i = s.u2;
    ex_memread_i = s.memrd;
    ex_rd_i = s.rd;
    id_branch_taken_i = s.br;
    mem_req_i = s.req;
    mem_ready_i = s.rdy;
    ex_mc_start_i = s.mcs;
    ex_mc_len_i = s.len;
    cyc++;
    e.cyc = cyc;
    if (s.rst) begin
      m_run = 0; m_rem = 0; m_lastw = 0; m_st = 0; m_fl = 0;
      e.v = 9'b0_0000_1111;
      e.st = 0; e.fl = 0;
      q.push_back(e);
    end else if (!m_run) begin
      e.v = 9'b0_0000_1111;
      e.st = m_st; e.fl = m_fl;
      q.push_back(e);
      if (s.start) m_run = 1;
    end else begin
      mw = s.req && !s.rdy;
      lu = s.memrd && (s.rd != 0) &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      pc = 1; h = 4'b0000; f = 4'b0000; brf = 0;
      if (mw) begin
        pc = 0; h = 4'b1111;
      end else if (m_rem > 0) begin
        pc = 0; h = 4'b1110; f = 4'b0001;
      end else if (lu) begin
        pc = 0; h = 4'b1000; f = 4'b0100;
      end else if (s.br) begin
        f = 4'b1000; brf = 1;
      end
      e.v = {pc, h, f};
      e.st = m_st; e.fl = m_fl;
      q.push_back(e);
      if (!pc) m_st++;
      if (brf) m_fl++;
      if (m_rem == 0 && !m_lastw && s.mcs && s.len >= 2)
        m_rem = int'(s.len) - 1;
      else if (m_rem > 0 && !mw)
        m_rem--;
      m_lastw = mw;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [8:0] got;
    if (q.size() != 0) begin
      e = q.pop_front();
      got = {pc_write_o, ifid_hold_o, idex_hold_o, exmem_hold_o,
             memwb_hold_o, ifid_flush_o, idex_flush_o, exmem_flush_o,
             memwb_flush_o};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL ctl_vec cyc=%0d got=%b exp=%b", e.cyc, got, e.v);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cycles_o !== 32'(e.st)) begin
        errors++;
        $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d",
                 e.cyc, stall_cycles_o, e.st);
      end
      checks++;
      if (flush_events_o !== 32'(e.fl)) begin
        errors++;
        $display("FAIL flush_events cyc=%0d got=%0d exp=%0d",
                 e.cyc, flush_events_o, e.fl);
      end
`endif
    end
  end

  task automatic directed();
    stim_t s;
    s = base(); s.rst = 1; s.start = 0;
    step(s); step(s);
    s = base(); s.start = 0;
    step(s); step(s);
    s.start = 1;
    step(s);
    step(base());
    s = base(); s.memrd = 1; s.rd = 5;
    s.rs1 = 5; s.u1 = 1; s.rs2 = 1; s.u2 = 1;
    step(s);
    step(base());
    s.rd = 0; s.rs1 = 0;
    step(s);
    s = base(); s.br = 1;
    step(s);
    step(base());
    s.memrd = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1;
    step(s);
    s = base(); s.br = 1;
    step(s);
    s = base(); s.req = 1;
    step(s); step(s); step(s);
    s.rdy = 1;
    step(s);
    step(base());
    s = base(); s.mcs = 1; s.len = 5;
    step(s);
    step(base());
    s = base(); s.req = 1;
    step(s); step(s);
    s.rdy = 1;
    step(s);
    step(base()); step(base()); step(base());
    s = base(); s.mcs = 1; s.len = 1;
    step(s);
    step(base());
    s.len = 0;
    step(s);
    s = base(); s.br = 1;
    step(s);
    s = base(); s.rst = 1;
    step(s);
    step(base());
    step(base());
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst   = ($urandom_range(0, 199) == 0);
    s.start = ($urandom_range(0, 3) != 0);
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.u1    = 1'($urandom_range(0, 1));
    s.u2    = 1'($urandom_range(0, 1));
    s.memrd = 1'($urandom_range(0, 1));
    s.rd    = 5'($urandom_range(0, 3));
    s.br    = ($urandom_range(0, 3) == 0);
    s.req   = ($urandom_range(0, 2) == 0);
    s.rdy   = 1'($urandom_range(0, 1));
    s.mcs   = ($urandom_range(0, 7) == 0);
    s.len   = 4'($urandom_range(0, 15));
    return s;
  endfunction

  initial begin
    directed();
    for (int i = 0; i < 1500; i++) begin
      step(rnd());
    end
    step(base());
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
